// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions: default operand/opcode widths, the
//               five legal opcode encodings and a legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_OPW   = 4;

  localparam logic [ALU_OPW-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OPW-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OPW-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OPW-1:0] ALU_NOT = 4'b0111;

  // True only for the five encodings the ALU implements.
  function automatic logic is_legal_op(input logic [ALU_OPW-1:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOT: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_arb2
// Description : Two-way round-robin arbiter. Grants combinationally while
//               the downstream slot is free; on a tie the requester that did
//               not win last time is chosen.
// Ports       : clk, reset       - clock, async active-high reset
//               valid[1:0]       - request lines
//               slot_free        - downstream can accept a transfer
//               grant[1:0]       - one-hot (or zero) grant
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       slot_free,
  output logic [1:0] grant
);

  // Index of the last winner. Reset to 1 so requester 0 wins the first tie.
  logic r_last_grant;

  always_comb begin
    grant = 2'b00;
    if (slot_free) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Any grant is a transfer because grant is only given to a valid requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (|grant) begin
      r_last_grant <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one EX-stage ALU between req0 (main issue) and req1
//               (branch/address helper). Round-robin grant, operands muxed
//               straight to the ALU, result captured into a one-entry
//               response register tagged with the winner id.
// Ports       : clk, reset                 - clock, async active-high reset
//               reqN_valid/ready/a/b/op    - requester handshakes (N=0,1)
//               alu_rs1/alu_rs2/alu_op     - to ALU (zero when no grant)
//               alu_result                 - from ALU, combinational
//               rsp_valid/ready/id/result  - response handshake
//               rsp_zero, rsp_err          - result==0, illegal opcode
//               grant_cnt0/1               - saturating transfer counters
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_rs1,
  output logic [WIDTH-1:0] alu_rs2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNTW-1:0]  grant_cnt0,
  output logic [CNTW-1:0]  grant_cnt1
);

  localparam logic [CNTW-1:0] c_cnt_one = CNTW'(1);
  localparam logic [CNTW-1:0] c_cnt_max = {CNTW{1'b1}};

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic [CNTW-1:0]  r_cnt0;
  logic [CNTW-1:0]  r_cnt1;

  logic             w_slot_free;
  logic [1:0]       w_grant;
  logic             w_xfer;

  // The slot accepts a new result if empty or being drained this cycle,
  // which is what gives one op per cycle under rsp_ready=1.
  assign w_slot_free = !r_rsp_valid || rsp_ready;

  alu_rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .valid     ({req1_valid, req0_valid}),
    .slot_free (w_slot_free),
    .grant     (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_xfer     = |w_grant;

  always_comb begin
    alu_rs1 = '0;
    alu_rs2 = '0;
    alu_op  = '0;
    if (w_grant[0]) begin
      alu_rs1 = req0_a;
      alu_rs2 = req0_b;
      alu_op  = req0_op;
    end else if (w_grant[1]) begin
      alu_rs1 = req1_a;
      alu_rs2 = req1_b;
      alu_op  = req1_op;
    end
  end

  // Response register. On a drain without a new transfer only the valid bit
  // drops; the payload keeps its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else if (w_xfer) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_grant[1];
      r_rsp_result <= alu_result;
      r_rsp_zero   <= (alu_result == '0);
      r_rsp_err    <= !is_legal_op(alu_op);
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_grant[0] && (r_cnt0 != c_cnt_max)) begin
        r_cnt0 <= r_cnt0 + c_cnt_one;
      end
      if (w_grant[1] && (r_cnt1 != c_cnt_max)) begin
        r_cnt1 <= r_cnt1 + c_cnt_one;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;
  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed bench for alu_share_arbiter. A default-width
//               instance and a CNTW=2 instance share stimulus; each has a
//               small behavioural ALU attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_ready;

  logic        req0_ready, req1_ready;
  logic [31:0] alu_rs1, alu_rs2, alu_result;
  logic [3:0]  alu_op;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_result;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic        s_req0_ready, s_req1_ready;
  logic [31:0] s_alu_rs1, s_alu_rs2, s_alu_result;
  logic [3:0]  s_alu_op;
  logic        s_rsp_valid, s_rsp_id, s_rsp_zero, s_rsp_err;
  logic [31:0] s_rsp_result;
  logic [1:0]  s_grant_cnt0, s_grant_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_NOT: return ~a;
      default: return 32'h0;
    endcase
  endfunction

  always_comb alu_result   = alu_f(alu_rs1, alu_rs2, alu_op);
  always_comb s_alu_result = alu_f(s_alu_rs1, s_alu_rs2, s_alu_op);

  alu_share_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  alu_share_arbiter #(.CNTW(2)) dut_sat (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_rs1(s_alu_rs1), .alu_rs2(s_alu_rs2), .alu_op(s_alu_op), .alu_result(s_alu_result),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
    .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero), .rsp_err(s_rsp_err),
    .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid",  32'(rsp_valid), 32'd0);
    chk("rst_id",     32'(rsp_id), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_zero",   32'(rsp_zero), 32'd0);
    chk("rst_err",    32'(rsp_err), 32'd0);
    chk("rst_cnt0",   32'(grant_cnt0), 32'd0);
    chk("rst_cnt1",   32'(grant_cnt1), 32'd0);

    // Contention: 4 cycles, expect grants 0,1,0,1
    tick();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = ALU_ADD;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd4; req1_op = ALU_OR;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_ready1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("cont_rs1",    alu_rs1, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("cont_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("cont_rsp_id",    32'(rsp_id), 32'd1);
    chk("cont_rsp_res",   rsp_result, 32'd6);
    chk("cont_cnt0",      32'(grant_cnt0), 32'd2);
    chk("cont_cnt1",      32'(grant_cnt1), 32'd2);
    chk("cont_scnt0",     32'(s_grant_cnt0), 32'd2);

    // Single op: ADD 5+7
    tick();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = ALU_ADD;
    @(negedge clk);
    chk("add_ready0", 32'(req0_ready), 32'd1);
    chk("add_aluop",  32'(alu_op), 32'(ALU_ADD));
    chk("add_rs2",    alu_rs2, 32'd7);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("add_valid",  32'(rsp_valid), 32'd1);
    chk("add_id",     32'(rsp_id), 32'd0);
    chk("add_result", rsp_result, 32'd12);
    chk("add_zero",   32'(rsp_zero), 32'd0);
    chk("add_cnt0",   32'(grant_cnt0), 32'd3);

    // Drain with no new transfer: valid drops, payload holds
    tick();
    @(negedge clk);
    chk("drain_valid",  32'(rsp_valid), 32'd0);
    chk("drain_result", rsp_result, 32'd12);
    chk("idle_rs1",     alu_rs1, 32'd0);

    // Backpressure: SUB 9-9 held while rsp_ready=0
    tick();
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_op = ALU_SUB;
    @(negedge clk);
    chk("bp_ready0_first", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h3C; req1_op = ALU_AND;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_valid",  32'(rsp_valid), 32'd1);
      chk("bp_result", rsp_result, 32'd0);
      chk("bp_zero",   32'(rsp_zero), 32'd1);
      chk("bp_id",     32'(rsp_id), 32'd0);
      chk("bp_ready0", 32'(req0_ready), 32'd0);
      chk("bp_ready1", 32'(req1_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid",  32'(rsp_valid), 32'd1);
    chk("bp_next_id",     32'(rsp_id), 32'd1);
    chk("bp_next_result", rsp_result, 32'h30);
    chk("bp_next_zero",   32'(rsp_zero), 32'd0);

    // Illegal opcode from req1
    tick();
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'b1111;
    @(negedge clk);
    chk("ill_ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("ill_err",    32'(rsp_err), 32'd1);
    chk("ill_id",     32'(rsp_id), 32'd1);
    chk("ill_result", rsp_result, 32'd0);
    chk("ill_cnt0",   32'(grant_cnt0), 32'd4);
    chk("ill_cnt1",   32'(grant_cnt1), 32'd4);

    // Reset asserted with a response in flight
    tick();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = ALU_ADD;
    tick();
    req0_valid = 1'b0;
    chk("pre_rst_valid",  32'(rsp_valid), 32'd1);
    chk("pre_rst_result", rsp_result, 32'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid",  32'(rsp_valid), 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    chk("mid_rst_err",    32'(rsp_err), 32'd0);
    chk("mid_rst_cnt0",   32'(grant_cnt0), 32'd0);
    chk("mid_rst_cnt1",   32'(grant_cnt1), 32'd0);
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = ALU_ADD;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd4; req1_op = ALU_OR;
    @(negedge clk);
    chk("post_rst_ready0", 32'(req0_ready), 32'd1);
    chk("post_rst_ready1", 32'(req1_ready), 32'd0);
    tick();
    req1_valid = 1'b0;

    // Saturation: five req0 transfers in total since reset
    repeat (4) @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("sat_main_cnt0", 32'(grant_cnt0), 32'd5);
    chk("sat_main_cnt1", 32'(grant_cnt1), 32'd0);
    chk("sat_small_cnt0", 32'(s_grant_cnt0), 32'd3);
    chk("sat_rsp_result", rsp_result, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
